// File: rtl/local_predictor.sv
`default_nettype none
// ============================================================================
// Module   : local_predictor
// Brief    : Four banks of 2-bit saturating direction counters. The GHR state
//            (local_src_i) picks the bank and PC[IDX_W+1:2] picks the entry.
//            Combinational fetch prediction, execute-stage training and a
//            combinational execute-stage mispredict flag.
//            Optional macro LOCAL_PRED_PERF_EN adds 32-bit trained-branch and
//            mispredict counters (branch_cnt_o / mispred_cnt_o).
// Revision : 1.0 - initial release
// ============================================================================
module local_predictor #(
  parameter int IDX_W = 6
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_f_i,
  input  logic [1:0]  local_src_i,
  output logic        pred_taken_f_o,
  input  logic        stall_e_i,
  input  logic [1:0]  branch_op_e_i,
  input  logic        pc_src_res_e_i,
  input  logic [31:0] pc_e_i,
  input  logic        pred_taken_e_i,
  output logic        mispredict_e_o
`ifdef LOCAL_PRED_PERF_EN
  ,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
`endif
);

  // Bank and entry concatenated form a flat table index.
  localparam int c_AW      = IDX_W + 2;
  localparam int c_ENTRIES = 4 << IDX_W;

  logic [1:0]      r_cnt [c_ENTRIES];
  logic [c_AW-1:0] w_rd_idx;
  logic [c_AW-1:0] w_wr_idx;
  logic [1:0]      w_old;
  logic [1:0]      w_new;
  logic            w_upd;
  logic            w_unused_bits;

  assign w_rd_idx = {local_src_i, pc_f_i[IDX_W+1:2]};
  assign w_wr_idx = {local_src_i, pc_e_i[IDX_W+1:2]};
  assign w_upd    = branch_op_e_i[0] & ~stall_e_i;
  assign w_old    = r_cnt[w_wr_idx];

  // Read sees only registered state, so a same-cycle write is not bypassed.
  assign pred_taken_f_o = r_cnt[w_rd_idx][1];
  assign mispredict_e_o = w_upd & (pred_taken_e_i ^ pc_src_res_e_i);

  // PC offset bits, bits above the index and branch_op bit 1 carry no meaning here.
  assign w_unused_bits = ^{pc_f_i[31:IDX_W+2], pc_f_i[1:0],
                           pc_e_i[31:IDX_W+2], pc_e_i[1:0], branch_op_e_i[1]};

  // Saturating increment on taken, saturating decrement on not taken.
  always_comb begin
    w_new = w_old;
    if (pc_src_res_e_i) begin
      if (w_old != 2'b11) w_new = w_old + 2'd1;
    end else begin
      if (w_old != 2'b00) w_new = w_old - 2'd1;
    end
  end

  // Counter table: reset to weakly-untaken, at most one entry written per cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < c_ENTRIES; i++) r_cnt[i] <= 2'b01;
    end else if (w_upd) begin
      r_cnt[w_wr_idx] <= w_new;
    end
  end

`ifdef LOCAL_PRED_PERF_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  // Free-running event counters; wrap naturally at 32 bits.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_branch_cnt  <= 32'd0;
      r_mispred_cnt <= 32'd0;
    end else begin
      if (w_upd)          r_branch_cnt  <= r_branch_cnt + 32'd1;
      if (mispredict_e_o) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign branch_cnt_o  = r_branch_cnt;
  assign mispred_cnt_o = r_mispred_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_local_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_local_predictor
// Brief    : Self-checking bench for local_predictor with a behavioural model
//            (array of saturating integers plus event counts).
// Revision : 1.0 - initial release
// ============================================================================
module tb_local_predictor;

  localparam int IDX_W = 6;
  localparam int N     = 1 << IDX_W;

  logic        clk_i          = 1'b0;
  logic        reset_i        = 1'b0;
  logic [31:0] pc_f_i         = '0;
  logic [1:0]  local_src_i    = '0;
  logic        stall_e_i      = 1'b0;
  logic [1:0]  branch_op_e_i  = '0;
  logic        pc_src_res_e_i = 1'b0;
  logic [31:0] pc_e_i         = '0;
  logic        pred_taken_e_i = 1'b0;
  wire         pred_taken_f_o;
  wire         mispredict_e_o;
`ifdef LOCAL_PRED_PERF_EN
  wire  [31:0] branch_cnt_o;
  wire  [31:0] mispred_cnt_o;
`endif

  local_predictor #(.IDX_W(IDX_W)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .pc_f_i         (pc_f_i),
    .local_src_i    (local_src_i),
    .pred_taken_f_o (pred_taken_f_o),
    .stall_e_i      (stall_e_i),
    .branch_op_e_i  (branch_op_e_i),
    .pc_src_res_e_i (pc_src_res_e_i),
    .pc_e_i         (pc_e_i),
    .pred_taken_e_i (pred_taken_e_i),
    .mispredict_e_o (mispredict_e_o)
`ifdef LOCAL_PRED_PERF_EN
    ,
    .branch_cnt_o   (branch_cnt_o),
    .mispred_cnt_o  (mispred_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  int          mdl [4][N];   // counter value 0..3 per bank/entry
  int unsigned m_br;
  int unsigned m_mp;

  function automatic int fidx(input logic [31:0] pc);
    return int'(pc[IDX_W+1:2]);
  endfunction

  function automatic logic exp_pred();
    return mdl[local_src_i][fidx(pc_f_i)] >= 2;
  endfunction

  function automatic logic exp_misp();
    return branch_op_e_i[0] & ~stall_e_i & (pred_taken_e_i ^ pc_src_res_e_i);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int e = 0; e < N; e++) mdl[b][e] = 1;
    m_br = 0;
    m_mp = 0;
  endtask

  // Advance one rising edge and apply the training rule to the model.
  task automatic tick();
    logic upd;
    int   b, e;
    upd = branch_op_e_i[0] & ~stall_e_i;
    b   = int'(local_src_i);
    e   = fidx(pc_e_i);
    @(posedge clk_i);
    if (upd && !reset_i) begin
      if (pc_src_res_e_i) mdl[b][e] = (mdl[b][e] == 3) ? 3 : mdl[b][e] + 1;
      else                mdl[b][e] = (mdl[b][e] == 0) ? 0 : mdl[b][e] - 1;
      m_br = m_br + 1;
      if (pred_taken_e_i ^ pc_src_res_e_i) m_mp = m_mp + 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    stall_e_i      = 1'b0;
    branch_op_e_i  = 2'b00;
    pc_src_res_e_i = 1'b0;
    pred_taken_e_i = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset_i = 1'b1;
    #1;
    model_reset();
    for (int b = 0; b < 4; b++) begin
      for (int e = 0; e < N; e++) begin
        local_src_i = 2'(b);
        pc_f_i      = ($urandom & 32'hFFFF_FF03) | (32'(e) << 2);
        #1;
        checks++;
        if (pred_taken_f_o !== 1'b0) begin
          errors++;
          $display("FAIL reset_pred bank=%0d idx=%0d got=%b want=0", b, e, pred_taken_f_o);
        end
      end
    end
`ifdef LOCAL_PRED_PERF_EN
    checks++;
    if (branch_cnt_o !== 32'd0 || mispred_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf got br=%0d mp=%0d want 0/0", branch_cnt_o, mispred_cnt_o);
    end
`endif
    @(posedge clk_i);
    #3 reset_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_sat_up();
    local_src_i    = 2'b01;
    pc_e_i         = 32'h0000_0010;
    pc_f_i         = 32'h0000_0010;
    branch_op_e_i  = 2'b01;
    stall_e_i      = 1'b0;
    pc_src_res_e_i = 1'b1;
    pred_taken_e_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (pred_taken_f_o !== exp_pred()) begin
        errors++;
        $display("FAIL sat_up_pred step=%0d got=%b want=%b", k, pred_taken_f_o, exp_pred());
      end
      if (k < 3) tick();
    end
    idle_inputs();
  endtask

  task automatic test_sat_down_isolation();
    pc_e_i         = 32'h0000_0010;
    pc_f_i         = 32'h0000_0010;
    branch_op_e_i  = 2'b01;
    pc_src_res_e_i = 1'b0;
    pred_taken_e_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      // Train bank 1 not-taken, then a final taken step distinguishes SU from WU.
      if (k == 3) pc_src_res_e_i = 1'b1;
      local_src_i = 2'b01;
      #1;
      checks++;
      if (pred_taken_f_o !== exp_pred()) begin
        errors++;
        $display("FAIL sat_down_pred step=%0d got=%b want=%b", k, pred_taken_f_o, exp_pred());
      end
      tick();
    end
    local_src_i = 2'b01;
    #1;
    checks++;
    if (pred_taken_f_o !== exp_pred()) begin
      errors++;
      $display("FAIL sat_down_final got=%b want=%b", pred_taken_f_o, exp_pred());
    end
    local_src_i = 2'b10;
    #1;
    checks++;
    if (pred_taken_f_o !== exp_pred()) begin
      errors++;
      $display("FAIL bank_isolation got=%b want=%b", pred_taken_f_o, exp_pred());
    end
    idle_inputs();
  endtask

  task automatic test_gating();
    for (int k = 0; k < 10; k++) begin
      local_src_i    = 2'($urandom);
      pc_e_i         = ($urandom & 32'hFFFF_FFE3) | 32'h10;
      stall_e_i      = (k < 5);
      branch_op_e_i  = (k < 5) ? 2'b01 : 2'b10;
      pc_src_res_e_i = 1'b1;
      pred_taken_e_i = 1'b0;
      #1;
      checks++;
      if (mispredict_e_o !== 1'b0) begin
        errors++;
        $display("FAIL gate_misp cycle=%0d got=%b want=0", k, mispredict_e_o);
      end
      tick();
    end
    idle_inputs();
    for (int b = 0; b < 4; b++) begin
      for (int e = 0; e < 8; e++) begin
        local_src_i = 2'(b);
        pc_f_i      = 32'(e) << 2;
        #1;
        checks++;
        if (pred_taken_f_o !== exp_pred()) begin
          errors++;
          $display("FAIL gate_table bank=%0d idx=%0d got=%b want=%b", b, e, pred_taken_f_o, exp_pred());
        end
      end
    end
  endtask

  task automatic test_collision();
    local_src_i    = 2'b00;
    pc_f_i         = 32'h0000_0020;
    pc_e_i         = 32'h0000_0020;
    branch_op_e_i  = 2'b01;
    stall_e_i      = 1'b0;
    pred_taken_e_i = 1'b0;
    pc_src_res_e_i = 1'b1;
    #1;
    checks++;
    if (pred_taken_f_o !== 1'b0 || pred_taken_f_o !== exp_pred()) begin
      errors++;
      $display("FAIL collide_old_pred got=%b want=0", pred_taken_f_o);
    end
    checks++;
    if (mispredict_e_o !== 1'b1) begin
      errors++;
      $display("FAIL collide_misp got=%b want=1", mispredict_e_o);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (pred_taken_f_o !== 1'b1 || pred_taken_f_o !== exp_pred()) begin
      errors++;
      $display("FAIL collide_new_pred got=%b want=1", pred_taken_f_o);
    end
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      local_src_i    = 2'($urandom);
      pc_f_i         = ($urandom & 32'hFFFF_FFE3) | (32'($urandom_range(0, 7)) << 2);
      pc_e_i         = ($urandom & 32'hFFFF_FFE3) | (32'($urandom_range(0, 7)) << 2);
      branch_op_e_i  = 2'($urandom);
      stall_e_i      = ($urandom_range(0, 3) == 0);
      pc_src_res_e_i = 1'($urandom);
      pred_taken_e_i = 1'($urandom);
      #1;
      checks++;
      if (pred_taken_f_o !== exp_pred()) begin
        errors++;
        $display("FAIL rand_pred iter=%0d got=%b want=%b", k, pred_taken_f_o, exp_pred());
      end
      checks++;
      if (mispredict_e_o !== exp_misp()) begin
        errors++;
        $display("FAIL rand_misp iter=%0d got=%b want=%b", k, mispredict_e_o, exp_misp());
      end
      tick();
`ifdef LOCAL_PRED_PERF_EN
      checks++;
      if (branch_cnt_o !== m_br || mispred_cnt_o !== m_mp) begin
        errors++;
        $display("FAIL rand_perf iter=%0d got br=%0d mp=%0d want br=%0d mp=%0d",
                 k, branch_cnt_o, mispred_cnt_o, m_br, m_mp);
      end
`endif
    end
    idle_inputs();
  endtask

  task automatic test_midop_reset();
    test_random(40);
    // Leave a taken update pending when reset hits mid-cycle.
    local_src_i    = 2'b11;
    pc_e_i         = 32'h0000_0004;
    branch_op_e_i  = 2'b01;
    pc_src_res_e_i = 1'b1;
    #2 reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    model_reset();
    idle_inputs();
    for (int b = 0; b < 4; b++) begin
      for (int e = 0; e < N; e++) begin
        local_src_i = 2'(b);
        pc_f_i      = 32'(e) << 2;
        #1;
        checks++;
        if (pred_taken_f_o !== 1'b0) begin
          errors++;
          $display("FAIL midop_reset bank=%0d idx=%0d got=%b want=0", b, e, pred_taken_f_o);
        end
      end
    end
    @(posedge clk_i);
    #3 reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    test_random(60);
  endtask

`ifdef LOCAL_PRED_PERF_EN
  task automatic test_perf();
    #2 reset_i = 1'b1;
    #2 reset_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 10; k++) begin
      local_src_i    = 2'($urandom);
      pc_e_i         = $urandom;
      branch_op_e_i  = 2'b01;
      stall_e_i      = 1'b0;
      pc_src_res_e_i = 1'($urandom);
      pred_taken_e_i = (k < 3) ? ~pc_src_res_e_i : pc_src_res_e_i;
      tick();
    end
    idle_inputs();
    checks++;
    if (branch_cnt_o !== 32'd10 || branch_cnt_o !== m_br) begin
      errors++;
      $display("FAIL perf_branch got=%0d want=10", branch_cnt_o);
    end
    checks++;
    if (mispred_cnt_o !== 32'd3 || mispred_cnt_o !== m_mp) begin
      errors++;
      $display("FAIL perf_mispred got=%0d want=3", mispred_cnt_o);
    end
    force dut.r_branch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_branch_cnt;
    branch_op_e_i  = 2'b01;
    pc_src_res_e_i = 1'b1;
    pred_taken_e_i = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (branch_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL perf_wrap got=%h want=00000000", branch_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sat_up();
    test_sat_down_isolation();
    test_gating();
    test_collision();
    test_random(300);
    test_midop_reset();
`ifdef LOCAL_PRED_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/local_predictor.md
# local_predictor

Bank of 2-bit saturating branch-direction counters consumed directly downstream of the global history register. The GHR's 2-bit history state (`local_src`) selects one of four counter banks and low PC bits select the entry. The block produces a taken/not-taken prediction for the fetch stage and trains the selected counter when a branch resolves in execute. It also flags execute-stage mispredictions for the branch-resolution logic.

## Interface
Parameters:
- `IDX_W`, default 6: PC index width; each bank holds 2^IDX_W counters, 4·2^IDX_W total.

Ports:
- `clk_i` in 1: clock; all state updates on rising edge.
- `reset_i` in 1: reset, **asynchronous, active-high**.
- `pc_f_i` in 32: fetch-stage PC; index = `pc_f_i[IDX_W+1:2]`.
- `local_src_i` in 2: GHR present state (UU=00, UT=01, TU=10, TT=11); selects bank for both read and update.
- `pred_taken_f_o` out 1: fetch-stage prediction, 1 = taken.
- `stall_e_i` in 1: execute stall; blocks training.
- `branch_op_e_i` in 2: execute branch op; bit 0 = conditional branch.
- `pc_src_res_e_i` in 1: resolved direction in execute, 1 = taken.
- `pc_e_i` in 32: execute-stage PC; index = `pc_e_i[IDX_W+1:2]`.
- `pred_taken_e_i` in 1: prediction originally made for the execute-stage instruction, piped down from fetch.
- `mispredict_e_o` out 1: execute-stage misprediction flag.
- `branch_cnt_o` out 32: trained-branch count (only with `LOCAL_PRED_PERF_EN`).
- `mispred_cnt_o` out 32: misprediction count (only with `LOCAL_PRED_PERF_EN`).

## Operation
- Storage: 4 banks × 2^IDX_W entries × 2-bit counter. Counter states are SU=00, WU=01, WT=10, ST=11.
- Read: `pred_taken_f_o` = bit 1 of `counter[local_src_i][pc_f_i[IDX_W+1:2]]`. The read is purely combinational from registered state.
- Train enable: `upd = branch_op_e_i[0] & ~stall_e_i`. This condition is identical to the GHR's update condition.
- Training writes entry `[local_src_i][pc_e_i[IDX_W+1:2]]`. `local_src_i` is the pre-update GHR state in that cycle.
  - Taken: counter saturating +1 (SU→WU→WT→ST, ST holds).
  - Not taken: counter saturating −1 (ST→WT→WU→SU, SU holds).
- No write when `upd`=0. Exactly one entry is written per cycle at most.
- `mispredict_e_o = upd & (pred_taken_e_i ^ pc_src_res_e_i)`. This output is combinational.
- PC bits [1:0] and bits above IDX_W+1 are ignored. Aliasing between PCs that share an index is accepted.

## Timing
- Prediction latency is 0 cycles: a combinational function of `pc_f_i`, `local_src_i` and the current table.
- A training update becomes visible on `pred_taken_f_o` from the cycle after the rising edge that writes it.
- Same-cycle read and write to the same entry: `pred_taken_f_o` shows the old value. There is no bypass.
- Reset assertion takes effect immediately, independent of `clk_i`:
  - every counter = WU (01);
  - `pred_taken_f_o` = 0;
  - perf counters = 0.
- `mispredict_e_o` follows its inputs combinationally, so it is 0 whenever `upd`=0.
- Reset asserted mid-operation discards any pending update in that cycle. Normal training resumes on the first edge after deassertion.
- While `stall_e_i`=1 the table is frozen, regardless of the other execute-stage inputs.

## Configuration
- Macro: `LOCAL_PRED_PERF_EN`.
- Defined:
  - `branch_cnt_o` increments by 1 on every edge with `upd`=1.
  - `mispred_cnt_o` increments by 1 on every edge with `mispredict_e_o`=1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by reset.
- Undefined: the `branch_cnt_o` and `mispred_cnt_o` ports and their registers do not exist. Prediction and training behaviour is identical in both builds.

## Test plan
- **Reset:** assert `reset_i` between clock edges.
  - All 256 entries (IDX_W=6) read WU, so `pred_taken_f_o`=0 for every PC and `local_src_i`.
  - Perf counters read 0.
- **Saturation up:** `local_src_i`=01, `pc_e_i`=0x0000_0010, `upd` with taken for 3 cycles.
  - Entry [1][4] goes WU→WT→ST→ST.
  - `pred_taken_f_o`=1 for `pc_f_i`=0x10 from cycle 2; the entry stays ST after the 3rd update.
- **Saturation down and bank isolation:** from ST, 3 not-taken updates on [1][4] give WT→WU→SU.
  - Same PC with `local_src_i`=10 still reads WU throughout.
- **Stall and non-branch gating:** `stall_e_i`=1 with `branch_op_e_i`=01, taken, for 5 cycles → no entry changes.
  - Same for `branch_op_e_i`=10 with `stall_e_i`=0.
  - `mispredict_e_o`=0 in all of those cycles.
- **Mispredict and read/write collision:** `pc_f_i`=`pc_e_i`=0x20, entry WU, `pred_taken_e_i`=0, taken.
  - Same cycle: `pred_taken_f_o`=0 and `mispredict_e_o`=1.
  - Next cycle: `pred_taken_f_o`=1.
- **Perf counters (macro defined):** 10 updates with 3 mispredicts → `branch_cnt_o`=10, `mispred_cnt_o`=3.
  - Preload 0xFFFFFFFF via force, then one update → `branch_cnt_o`=0.
